// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared K=7 code constants, encoder state enum and parity helper.
package viterbi_pkg;
   localparam int K = 7;
   localparam int MEM = K - 1;
   localparam int NUM_STATES = 1 << MEM;
   localparam logic [K-1:0] G0_DEF = 7'o171;
   localparam logic [K-1:0] G1_DEF = 7'o133;
   typedef enum logic {DATA, TAIL} enc_state_t;
   function automatic logic parity(input logic [K-1:0] w, input logic [K-1:0] g);
      return ^(w & g);
   endfunction
endpackage

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7: rate-1/2 K=7 convolutional encoder with optional zero-tail termination.
module conv_encoder_k7 import viterbi_pkg::*; #(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF,
   parameter bit TAIL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bit,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [1:0] out_pair,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready
);
   enc_state_t state, state_nx;
   logic [MEM-1:0] sr;
   logic [2:0] tail_cnt, tail_cnt_nx;
   logic slot_free, enc, bit_enc, last_sym;
   logic [K-1:0] w;
   assign slot_free = !out_valid | out_ready;
   assign in_ready = !rst & (state == DATA) & slot_free;
   // Tail symbols are generated whenever the output slot frees up; data waits on the input handshake.
   always_comb begin
      bit_enc = (state == DATA) ? in_bit : 1'b0;
      enc = (state == DATA) ? (in_valid & in_ready) : slot_free;
      w = {bit_enc, sr};
      last_sym = (state == TAIL) ? (tail_cnt == 3'd5) : (in_last & !TAIL_EN);
      state_nx = state;
      tail_cnt_nx = tail_cnt;
      if (enc && state == DATA && in_last && TAIL_EN) begin
         state_nx = TAIL;
         tail_cnt_nx = 3'd0;
      end
      if (enc && state == TAIL) begin
         tail_cnt_nx = tail_cnt + 3'd1;
         state_nx = (tail_cnt == 3'd5) ? DATA : TAIL;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DATA;
         tail_cnt <= 3'd0;
         sr <= '0;
         out_valid <= 1'b0;
         out_pair <= 2'b00;
         out_last <= 1'b0;
      end else begin
         state <= state_nx;
         tail_cnt <= tail_cnt_nx;
         if (enc) begin
            out_pair <= {parity(w, G1), parity(w, G0)};
            out_last <= last_sym;
            out_valid <= 1'b1;
            sr <= last_sym ? '0 : {bit_enc, sr[MEM-1:1]};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule
